// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-wide backing-memory port between the
// instruction cache and the data cache. One 128-bit block transaction is in
// flight at a time; the winner's address/data/op are latched on grant.
// A watchdog flags a memory that stays busy too long within a single grant.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined: fixed priority, the data cache wins simultaneous requests.
//   defined:   on simultaneous requests, the port not served last wins.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 28,
    parameter int BLOCK_WIDTH    = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   INST_MEM_READ,
    input  logic [ADDR_WIDTH-1:0]  INST_MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] INST_MEM_READDATA,
    output logic                   INST_MEM_BUSYWAIT,
    input  logic                   DATA_MEM_READ,
    input  logic                   DATA_MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0]  DATA_MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] DATA_MEM_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] DATA_MEM_READDATA,
    output logic                   DATA_MEM_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT,
    output logic                   TIMEOUT_ERR
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        GRANT_I,
        GRANT_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t state;
    state_t state_next;

    logic                   inst_req;
    logic                   data_req;
    logic                   pick_data;
    logic                   in_grant;
    logic                   grant_start;
    logic                   grant_done;
    logic                   first_cycle;
    logic                   op_write;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BLOCK_WIDTH-1:0] wdata_q;
    logic [BLOCK_WIDTH-1:0] inst_rdata;
    logic [BLOCK_WIDTH-1:0] data_rdata;
    logic [7:0]             wd_count;
    logic                   timeout_q;

    assign inst_req = INST_MEM_READ;
    assign data_req = DATA_MEM_READ | DATA_MEM_WRITE;
    assign in_grant = (state == GRANT_I) || (state == GRANT_D);

    // The memory may not have registered the strobe yet in the first grant
    // cycle, so its busywait is only trusted from the second cycle on.
    assign grant_done  = in_grant && !first_cycle && !MEM_BUSYWAIT;
    assign grant_start = (state == IDLE) && (state_next != IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data;

    // Record which port completed most recently; reset points at DATA so the first tie goes to inst.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            last_data <= 1'b1;
        end else if (state == DONE_D) begin
            last_data <= 1'b1;
        end else if (state == DONE_I) begin
            last_data <= 1'b0;
        end
    end

    // Round-robin winner select: ties go to the port not served last.
    always_comb begin
        pick_data = data_req && (!inst_req || !last_data);
    end
`else
    // Fixed-priority winner select: the data cache wins ties.
    always_comb begin
        pick_data = data_req;
    end
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: arbitrate only in IDLE, leave GRANT on completion, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_data) begin
                    state_next = GRANT_D;
                end else if (inst_req) begin
                    state_next = GRANT_I;
                end
            end
            GRANT_I: begin
                if (grant_done) begin
                    state_next = DONE_I;
                end
            end
            GRANT_D: begin
                if (grant_done) begin
                    state_next = DONE_D;
                end
            end
            DONE_I:  state_next = IDLE;
            DONE_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's address, write block and operation when a grant starts.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            op_write    <= 1'b0;
            first_cycle <= 1'b0;
        end else begin
            first_cycle <= grant_start;
            if (state == IDLE) begin
                if (pick_data) begin
                    addr_q   <= DATA_MEM_ADDRESS;
                    wdata_q  <= DATA_MEM_WRITEDATA;
                    op_write <= DATA_MEM_WRITE;
                end else if (inst_req) begin
                    addr_q   <= INST_MEM_ADDRESS;
                    op_write <= 1'b0;
                end
            end
        end
    end

    // Capture the returned block into the granted port's readdata register on read completion.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else if (grant_done && !op_write) begin
            if (state == GRANT_I) begin
                inst_rdata <= MEM_READDATA;
            end else begin
                data_rdata <= MEM_READDATA;
            end
        end
    end

    // Watchdog: count busy cycles within one grant (saturating); the error flag is sticky.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wd_count  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wd_count == TIMEOUT_CNT) begin
                timeout_q <= 1'b1;
            end
            if (grant_start) begin
                wd_count <= '0;
            end else if (in_grant && MEM_BUSYWAIT && (wd_count != 8'hFF)) begin
                wd_count <= wd_count + 8'd1;
            end
        end
    end

    assign MEM_READ      = in_grant && !op_write;
    assign MEM_WRITE     = (state == GRANT_D) && op_write;
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;

    assign INST_MEM_READDATA = inst_rdata;
    assign DATA_MEM_READDATA = data_rdata;

    // Stall a requesting port everywhere except its own DONE cycle; held low while in reset.
    assign INST_MEM_BUSYWAIT = RESET && inst_req && (state != DONE_I);
    assign DATA_MEM_BUSYWAIT = RESET && data_req && (state != DONE_D);

    assign TIMEOUT_ERR = timeout_q;

endmodule
